// File: rtl/riscv_core_ctrl_pkg.sv
// Shared types and constants for the RV32 multi-cycle control sequencer.
// Holds the FSM state and trap-cause enums plus the decoder class encodings.
package riscv_core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } ctrl_state_e;

    typedef enum logic [1:0] {
        TRAP_NONE     = 2'd0,
        TRAP_ILLEGAL  = 2'd1,
        TRAP_FETCH_TO = 2'd2,
        TRAP_MISALIGN = 2'd3
    } trap_cause_e;

    typedef enum logic {
        RF_NONE  = 1'b0,
        RF_WRITE = 1'b1
    } rf_wen_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_JUMP   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JALR   = 2'd3
    } pc_sel_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Instructions are 4-byte aligned; bit 0 is already cleared by the caller.
    function automatic logic target_misaligned(input logic [31:0] tgt);
        return tgt[1];
    endfunction

endpackage

// File: rtl/riscv_fetch_timer.sv
// Fetch timeout down-counter: reloads while not waiting on memory, counts down
// each unacknowledged FETCH cycle and flags the terminal count.
module riscv_fetch_timer #(
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic expired
);

    localparam logic [7:0] LOAD_VAL = 8'(FETCH_TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (tick && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 8'd0);

endmodule

// File: rtl/riscv_core_ctrl.sv
// Multi-cycle sequencer for the single-issue RV32 core: owns PC, instruction
// register and instret, and drives the imem request/ack handshake.
//   state  | meaning
//   IDLE   | halted, waiting for run
//   FETCH  | imem_req high at pc, waiting for ack or timeout
//   DECODE | decoder looks at inst; illegal -> TRAP
//   EXEC   | one cycle of ALU settle time
//   WB     | writeback strobe, next-PC select, retire
//   TRAP   | sticky error halt, left only by rst
module riscv_core_ctrl
    import riscv_core_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    input  logic        dec_valid,
    input  rf_wen_e     dec_rf_wen,
    input  pc_sel_e     dec_pc_sel,
    input  logic [31:0] alu_result,
    output logic [31:0] pc,
    output logic        rf_we,
    output logic        retire,
    output logic [31:0] instret,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic        busy
);

    ctrl_state_e state_q, state_d;
    trap_cause_e cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] target;
    logic        tmr_load;
    logic        tmr_tick;
    logic        tmr_expired;

    riscv_fetch_timer #(
        .FETCH_TIMEOUT(FETCH_TIMEOUT)
    ) u_fetch_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .tick   (tmr_tick),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        imem_req  = 1'b0;
        rf_we     = 1'b0;
        retire    = 1'b0;
        tmr_load  = 1'b1;
        tmr_tick  = 1'b0;
        target    = (dec_pc_sel == PC_PLUS4) ? (pc_q + PC_STEP)
                                             : (alu_result & ~32'h0000_0001);

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                tmr_load = 1'b0;
                // Ack is checked first so a late ack on the last cycle still completes.
                if (imem_ack) begin
                    inst_d   = imem_rdata;
                    tmr_load = 1'b1;
                    state_d  = ST_DECODE;
                end else if (tmr_expired) begin
                    cause_d = TRAP_FETCH_TO;
                    state_d = ST_TRAP;
                end else begin
                    tmr_tick = 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec_valid) begin
                    state_d = ST_EXEC;
                end else begin
                    cause_d = TRAP_ILLEGAL;
                    state_d = ST_TRAP;
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                if (target_misaligned(target)) begin
                    cause_d = TRAP_MISALIGN;
                    state_d = ST_TRAP;
                end else begin
                    pc_d      = target;
                    rf_we     = (dec_rf_wen == RF_WRITE);
                    retire    = 1'b1;
                    instret_d = instret_q + 32'd1;
                    state_d   = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cause_q   <= TRAP_NONE;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign instret    = instret_q;
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_TRAP);

endmodule

// File: tb/tb_riscv_core_ctrl.sv
// Scoreboard bench for riscv_core_ctrl: stimulus predicts each instruction's
// outcome from the architectural rules, a negedge monitor checks what the core does.
module tb_riscv_core_ctrl;
    import riscv_core_ctrl_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          FT     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        dec_valid;
    rf_wen_e     dec_rf_wen;
    pc_sel_e     dec_pc_sel;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        rf_we;
    logic        retire;
    logic [31:0] instret;
    logic        trap;
    logic [1:0]  trap_cause;
    logic        busy;

    riscv_core_ctrl #(
        .RESET_PC     (RST_PC),
        .FETCH_TIMEOUT(FT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .inst      (inst),
        .dec_valid (dec_valid),
        .dec_rf_wen(dec_rf_wen),
        .dec_pc_sel(dec_pc_sel),
        .alu_result(alu_result),
        .pc        (pc),
        .rf_we     (rf_we),
        .retire    (retire),
        .instret   (instret),
        .trap      (trap),
        .trap_cause(trap_cause),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          lat;
        bit          is_trap;
        logic [31:0] cause;
        logic [31:0] rf_we;
        logic [31:0] pc;
        logic [31:0] instret;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instret;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_cause", 32'(trap_cause), 32'd0);
        check("rst_pc", pc, RST_PC);
        check("rst_instret", instret, 32'd0);
        check("rst_inst", inst, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc = RST_PC;
        m_instret = 32'd0;
        check_reset();
    endtask

    // d >= FT means the ack is withheld entirely.
    task automatic run_inst(input int d, input bit valid, input bit wen, input pc_sel_e sel,
                            input logic [31:0] alu, input bit drop, input logic [31:0] word);
        exp_t e;
        logic [31:0] tgt;
        bit found;
        bit done;
        @(posedge clk); #1;
        dec_valid  = valid;
        dec_rf_wen = wen ? RF_WRITE : RF_NONE;
        dec_pc_sel = sel;
        alu_result = alu;
        run        = 1'b1;

        e.addr = m_pc; e.rf_we = 0; e.is_trap = 1; e.cause = 0;
        e.pc = m_pc; e.instret = m_instret; e.lat = 0;
        if (d >= FT) begin
            e.cause = 2; e.lat = FT;
        end else if (!valid) begin
            e.cause = 1; e.lat = d + 2;
        end else begin
            tgt = (sel == PC_PLUS4) ? m_pc + 32'd4 : alu - (alu % 2);
            if ((tgt / 2) % 2 == 1) begin
                e.cause = 3; e.lat = d + 4;
            end else begin
                e.is_trap = 0; e.lat = d + 3; e.rf_we = 32'(wen);
                m_pc = tgt; m_instret = m_instret + 32'd1;
                e.pc = m_pc; e.instret = m_instret;
            end
        end
        exp_q.push_back(e);

        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin found = 1; break; end
            @(posedge clk); #1;
        end
        if (!found) begin
            check("fetch_start_timeout", 32'd0, 32'd1);
            do_reset();
            return;
        end

        if (d < FT) begin
            repeat (d) begin @(posedge clk); #1; end
            imem_ack = 1'b1; imem_rdata = word;
            @(posedge clk); #1;
            imem_ack = 1'b0; imem_rdata = $urandom;
            if (drop) run = 1'b0;
            check("inst_latch", inst, word);
        end

        done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (retire || trap) begin done = 1; break; end
        end
        if (!done) begin
            check("completion_timeout", 32'd0, 32'd1);
            do_reset();
            return;
        end

        if (trap) begin
            imem_ack = 1'b1; run = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check("trap_sticky", 32'(trap), 32'd1);
                check("trap_busy", 32'(busy), 32'd0);
                check("trap_req", 32'(imem_req), 32'd0);
                check("trap_pc", pc, m_pc);
            end
            imem_ack = 1'b0;
            do_reset();
        end else if (drop) begin
            repeat (2) begin
                @(negedge clk);
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_req", 32'(imem_req), 32'd0);
            end
        end
    endtask

    task automatic abort_fetch();
        exp_t e;
        bit found;
        @(posedge clk); #1;
        run = 1'b1;
        e.addr = m_pc; e.lat = 999; e.is_trap = 0; e.cause = 0;
        e.rf_we = 0; e.pc = m_pc; e.instret = m_instret;
        exp_q.push_back(e);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin found = 1; break; end
            @(posedge clk); #1;
        end
        check("abort_fetch_seen", 32'(found), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b0; imem_ack = 1'b0; run = 1'b0;
        m_pc = RST_PC; m_instret = 32'd0;
        check_reset();
    endtask

    // Monitor: latency is counted from the cycle imem_req rises for an instruction.
    initial begin
        exp_t e;
        int idx;
        bit active, pend, req_prev, trap_prev;
        logic [31:0] pp, pi;
        idx = 0; active = 0; pend = 0; req_prev = 0; trap_prev = 0; pp = 0; pi = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                active = 0;
                pend = 0;
            end else begin
                if (pend) begin
                    check("post_pc", pc, pp);
                    check("post_instret", instret, pi);
                    pend = 0;
                end
                if (active) idx++;
                if (imem_req && !req_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_fetch", 32'd1, 32'd0);
                    end else begin
                        check("fetch_addr", imem_addr, exp_q[0].addr);
                        active = 1;
                        idx = 0;
                    end
                end
                if (active && (retire || (trap && !trap_prev))) begin
                    e = exp_q.pop_front();
                    active = 0;
                    check("latency", 32'(idx), 32'(e.lat));
                    check("outcome_trap", 32'(trap), 32'(e.is_trap));
                    if (e.is_trap) begin
                        check("trap_cause", 32'(trap_cause), e.cause);
                        check("trap_pc_kept", pc, e.pc);
                        check("trap_no_retire", 32'(retire), 32'd0);
                        check("trap_no_rf_we", 32'(rf_we), 32'd0);
                    end else begin
                        check("wb_rf_we", 32'(rf_we), e.rf_we);
                        pend = 1; pp = e.pc; pi = e.instret;
                    end
                end
            end
            req_prev  = imem_req;
            trap_prev = trap;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int d, r;
        bit valid, wen, drop;
        pc_sel_e sel;
        logic [31:0] alu;
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        dec_valid = 1'b0; dec_rf_wen = RF_NONE; dec_pc_sel = PC_PLUS4; alu_result = 32'd0;
        m_pc = RST_PC; m_instret = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset();

        run_inst(0, 1, 1, PC_PLUS4, 32'd0, 0, 32'h0050_0093);
        run_inst(3, 1, 1, PC_PLUS4, 32'd0, 0, 32'h0020_81B3);
        run_inst(3, 1, 1, PC_PLUS4, 32'd0, 0, 32'h0050_0093);
        run_inst(0, 1, 0, PC_JUMP, 32'h0000_0200, 0, 32'h0000_006F);
        run_inst(0, 0, 0, PC_PLUS4, 32'd0, 0, 32'hFFFF_FFFF);
        run_inst(FT, 1, 1, PC_PLUS4, 32'd0, 0, 32'h0050_0093);
        run_inst(3, 1, 1, PC_PLUS4, 32'd0, 0, 32'h0050_0093);
        run_inst(0, 1, 0, PC_JUMP, 32'h0000_0302, 0, 32'h0000_006F);
        run_inst(0, 1, 1, PC_JUMP, 32'h0000_0301, 0, 32'h0000_006F);
        run_inst(1, 1, 1, PC_PLUS4, 32'd0, 1, 32'h0050_0093);
        run_inst(0, 1, 1, PC_PLUS4, 32'd0, 0, 32'h0020_81B3);
        run_inst(0, 1, 0, PC_JUMP, 32'hFFFF_FFFC, 0, 32'h0000_006F);
        run_inst(2, 1, 1, PC_PLUS4, 32'd0, 0, 32'h0050_0093);
        abort_fetch();

        for (int n = 0; n < 150; n++) begin
            d     = ($urandom_range(0, 11) == 0) ? FT : int'($urandom_range(0, 3));
            valid = ($urandom_range(0, 15) != 0);
            wen   = 1'($urandom_range(0, 1));
            r     = int'($urandom_range(0, 3));
            sel   = pc_sel_e'(2'(r));
            alu   = m_pc + 32'($urandom_range(0, 256)) * 32'd4
                  + (($urandom_range(0, 5) == 0) ? 32'($urandom_range(2, 3))
                                                 : 32'($urandom_range(0, 1)));
            drop  = ($urandom_range(0, 4) == 0);
            run_inst(d, valid, wen, sel, alu, drop, $urandom);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
